// File: rtl/rename_pkg.sv
// Shared types and constants for the register rename stage.
package rename_pkg;

    localparam int unsigned PREG_WIDTH = 7;
    localparam int unsigned AREG_WIDTH = 5;
    localparam int unsigned NUM_AREGS  = 32;

    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [AREG_WIDTH-1:0] areg_t;
    typedef preg_t [NUM_AREGS-1:0] rat_t;

    typedef struct packed {
        preg_t prs1;
        preg_t prs2;
        preg_t prd;
        preg_t old_prd;
        logic  rd_we;
        logic  is_branch;
    } renamed_uop_t;

    // Out of reset every architectural register maps to the physical register with the same index.
    function automatic rat_t identity_rat();
        rat_t r;
        for (int unsigned i = 0; i < NUM_AREGS; i++) begin
            r[i] = PREG_WIDTH'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/map_table.sv
// Architectural-to-physical map table with a single branch checkpoint copy.
module map_table
    import rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AREG_WIDTH-1:0] rs1_i,
    input  logic [AREG_WIDTH-1:0] rs2_i,
    input  logic [AREG_WIDTH-1:0] rd_i,
    input  logic                  we_i,
    input  logic [PREG_WIDTH-1:0] wdata_i,
    input  logic                  save_i,
    input  logic                  restore_i,
    output logic [PREG_WIDTH-1:0] prs1_o,
    output logic [PREG_WIDTH-1:0] prs2_o,
    output logic [PREG_WIDTH-1:0] old_prd_o
);

    rat_t rat_q, rat_d;
    rat_t ckpt_q;

    // Reads see the table before this cycle's update.
    assign prs1_o    = rat_q[rs1_i];
    assign prs2_o    = rat_q[rs2_i];
    assign old_prd_o = rat_q[rd_i];

    always_comb begin
        rat_d = rat_q;
        if (restore_i) begin
            rat_d = ckpt_q;
        end else if (we_i) begin
            rat_d[rd_i] = wdata_i;
        end
    end

    // Checkpoint captures the post-update table so a branch's own rd write survives a restore.
    always_ff @(posedge clk) begin
        if (reset) begin
            rat_q  <= identity_rat();
            ckpt_q <= identity_rat();
        end else begin
            rat_q <= rat_d;
            if (save_i && !restore_i) begin
                ckpt_q <= rat_d;
            end
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Single-issue rename stage: RAT lookup, free-list allocation, one branch checkpoint,
// and a one-entry valid/ready output register toward dispatch.
module rename_stage
    import rename_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AREG_WIDTH-1:0] in_rs1,
    input  logic [AREG_WIDTH-1:0] in_rs2,
    input  logic [AREG_WIDTH-1:0] in_rd,
    input  logic                  in_rd_we,
    input  logic                  in_is_branch,
    output logic                  fl_alloc_req,
    input  logic [PREG_WIDTH-1:0] fl_alloc_preg,
    input  logic                  fl_alloc_valid,
    output logic                  fl_is_branch_dispatch,
    input  logic                  branch_mispredict,
    input  logic                  branch_resolved,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PREG_WIDTH-1:0] out_prs1,
    output logic [PREG_WIDTH-1:0] out_prs2,
    output logic [PREG_WIDTH-1:0] out_prd,
    output logic [PREG_WIDTH-1:0] out_old_prd,
    output logic                  out_rd_we,
    output logic                  out_is_branch
);

    logic         we_eff;
    logic         fire;
    logic         ckpt_busy_q;
    logic         restore;
    logic         out_valid_q;
    renamed_uop_t uop_q, uop_d;
    preg_t        rat_prs1, rat_prs2, rat_old_prd;

    assign we_eff  = in_rd_we && (in_rd != AREG_WIDTH'(0));
    assign restore = branch_mispredict && ckpt_busy_q;

    assign in_ready = !reset
                   && (!out_valid_q || out_ready)
                   && (!we_eff || fl_alloc_valid)
                   && !(in_is_branch && ckpt_busy_q)
                   && !branch_mispredict;

    assign fire                  = in_valid && in_ready;
    assign fl_alloc_req          = fire && we_eff;
    assign fl_is_branch_dispatch = fire && in_is_branch;

    map_table u_map_table (
        .clk       (clk),
        .reset     (reset),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .rd_i      (in_rd),
        .we_i      (fl_alloc_req),
        .wdata_i   (fl_alloc_preg),
        .save_i    (fl_is_branch_dispatch),
        .restore_i (restore),
        .prs1_o    (rat_prs1),
        .prs2_o    (rat_prs2),
        .old_prd_o (rat_old_prd)
    );

    always_comb begin
        uop_d           = '0;
        uop_d.prs1      = rat_prs1;
        uop_d.prs2      = rat_prs2;
        uop_d.prd       = we_eff ? fl_alloc_preg : PREG_WIDTH'(0);
        uop_d.old_prd   = we_eff ? rat_old_prd : PREG_WIDTH'(0);
        uop_d.rd_we     = in_rd_we;
        uop_d.is_branch = in_is_branch;
    end

    // Output register: load on fire, hold under backpressure, drop on drain or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            uop_q       <= '0;
        end else if (branch_mispredict) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            uop_q       <= uop_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // A branch can only fire while no checkpoint is held, so set and resolve never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            ckpt_busy_q <= 1'b0;
        end else if (branch_mispredict) begin
            ckpt_busy_q <= 1'b0;
        end else if (fl_is_branch_dispatch) begin
            ckpt_busy_q <= 1'b1;
        end else if (branch_resolved) begin
            ckpt_busy_q <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_prs1      = uop_q.prs1;
    assign out_prs2      = uop_q.prs2;
    assign out_prd       = uop_q.prd;
    assign out_old_prd   = uop_q.old_prd;
    assign out_rd_we     = uop_q.rd_we;
    assign out_is_branch = uop_q.is_branch;

endmodule

// File: doc/rename_stage.md
# rename_stage

Single-issue register rename stage between decode and dispatch. It holds the 32-entry architectural-to-physical map table (RAT) and translates rs1/rs2/rd of each decoded instruction. It allocates a destination physical register from the free list and keeps one branch checkpoint of the RAT, matching the free list's single head-pointer shadow. Renamed instructions leave through a one-entry valid/ready output register toward dispatch/ROB.

## Interface
- PREG_WIDTH, 7, physical register index width (128 pregs)
- AREG_WIDTH, 5, architectural register index width (32 aregs)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  decode has an instruction
- in_ready  out  1  rename accepts this cycle
- in_rs1, in_rs2, in_rd  in  AREG_WIDTH  architectural sources and destination
- in_rd_we  in  1  instruction writes rd
- in_is_branch  in  1  instruction needs a checkpoint
- fl_alloc_req  out  1  free-list allocate strobe
- fl_alloc_preg  in  PREG_WIDTH  head of free list
- fl_alloc_valid  in  1  free list non-empty
- fl_is_branch_dispatch  out  1  free-list snapshot strobe
- branch_mispredict  in  1  restore RAT from checkpoint, flush output
- branch_resolved  in  1  checkpointed branch predicted correctly; release checkpoint
- out_valid  out  1  renamed instruction available
- out_ready  in  1  dispatch accepts
- out_prs1, out_prs2, out_prd, out_old_prd  out  PREG_WIDTH  renamed operands; old_prd goes to the ROB for freeing at commit
- out_rd_we, out_is_branch  out  1  pass-through flags

## Operation
- Effective write: we_eff = in_rd_we && (in_rd != 0). x0 is never renamed. If we_eff=0, out_prd=0 and out_old_prd=0.
- fire = in_valid && in_ready.
- in_ready = (!out_valid || out_ready) && (!we_eff || fl_alloc_valid) && !(in_is_branch && ckpt_busy) && !branch_mispredict.
- fl_alloc_req = fire && we_eff. fl_is_branch_dispatch = fire && in_is_branch. Both are combinational.
- On fire:
  - prs1 = RAT[rs1] and prs2 = RAT[rs2], read before this instruction's own update.
  - old_prd = RAT[rd].
  - If we_eff, RAT[rd] <= fl_alloc_preg.
- On a branch fire:
  - ckpt <= RAT including this instruction's rd update, so a JAL's link write survives.
  - ckpt_busy <= 1.
- branch_resolved clears ckpt_busy. It is ignored when ckpt_busy=0.
- branch_mispredict takes priority over everything:
  - RAT <= ckpt, ckpt_busy <= 0, out_valid <= 0.
  - No fire in that cycle.
  - If no checkpoint is held, the RAT is left unchanged and only the flush occurs.
- A checkpoint is held by at most one branch. A second branch stalls until resolve or mispredict.

## Timing
- Reset values:
  - RAT[i] = i and ckpt[i] = i.
  - ckpt_busy = 0, out_valid = 0.
  - All out_* data outputs = 0.
  - in_ready, fl_alloc_req and fl_is_branch_dispatch are 0 during reset.
- Latency is 1 cycle: a fire at cycle N presents out_valid at N+1.
- Full throughput is 1 instruction per cycle while out_ready=1.
- Output register:
  - Holds its data stable while out_valid && !out_ready.
  - Loads on fire.
  - Clears when out_ready && !fire.
- ckpt_busy is registered. A resolve and a new branch in the same cycle still stall that branch; it is accepted the following cycle.
- Free list empty with we_eff=1: stall. Instructions with we_eff=0 still proceed.
- Reset mid-stream discards the output register and the checkpoint.

## Structure
- Shared package rename_pkg:
  - PREG_WIDTH and AREG_WIDTH constants.
  - preg_t and areg_t typedefs.
  - rat_t = preg_t [32] typedef.
  - renamed_uop_t struct carrying the out_* fields.
- Natural sub-module map_table: RAT storage, two read ports plus an old_prd read port, one write port, a checkpoint copy, and restore. rename_stage wraps it with the handshake and output register.

## Test plan
- Reset, then rename add x5,x1,x2 with fl_alloc_preg=32 -> next cycle out_prs1=1, out_prs2=2, out_prd=32, out_old_prd=5; RAT[5]=32.
- Back-to-back x5<-x5 (alloc 32) then x6<-x5 (alloc 33) -> second instruction out_prs1=32, out_old_prd=6.
- in_rd=0 with in_rd_we=1 -> fl_alloc_req=0, out_prd=0, RAT unchanged. fl_alloc_valid=0 with we_eff=1 -> in_ready=0 until it returns to 1.
- Branch (no rd) fires, then x7<-… allocates 40, then branch_mispredict -> RAT[7]=7 again, out_valid=0, ckpt_busy=0; next instruction writing x7 reads old_prd=7.
- Branch held; second branch stalls (in_ready=0) -> branch_resolved in cycle N, second branch fires at N+1 with fl_is_branch_dispatch=1.
- out_ready=0 for 3 cycles while out_valid=1 -> outputs stable, in_ready=0, no fl_alloc_req; release -> one instruction retires per cycle.
